// File: rtl/unidade_pc_pkg.sv
// Shared definitions for the PC unit: operation encoding and default widths.
// The control unit imports this package so both sides agree on Operacao.
package unidade_pc_pkg;

  localparam int LARGURA_PC_PADRAO   = 8;
  localparam int PROFUNDIDADE_PADRAO = 4;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'b000,
    OP_BEQ  = 3'b001,
    OP_BNE  = 3'b010,
    OP_JMP  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_HALT = 3'b110,
    OP_RES  = 3'b111
  } operacao_t;

endpackage

// File: rtl/unidade_pc_pilha_retorno.sv
// Return-address LIFO: register array plus an occupancy pointer that is one bit
// wider than the index, so an empty stack and a full stack have distinct encodings.
module pilha_retorno #(
  parameter int LARGURA      = 8,
  parameter int PROFUNDIDADE = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [LARGURA-1:0] dado_i,
  output logic [LARGURA-1:0] topo_o,
  output logic               vazia_o,
  output logic               cheia_o
);

  localparam int PW = $clog2(PROFUNDIDADE) + 1;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-2:0]      idx_topo;
  logic               vazia_q, cheia_q;
  logic [LARGURA-1:0] mem_q [PROFUNDIDADE];

  assign idx_topo = ptr_q[PW-2:0] - (PW-1)'(1);
  assign topo_o   = mem_q[idx_topo];
  assign vazia_o  = vazia_q;
  assign cheia_o  = cheia_q;

  always_comb begin
    ptr_d = ptr_q;
    if (push_i)
      ptr_d = ptr_q + PW'(1);
    else if (pop_i)
      ptr_d = ptr_q - PW'(1);
  end

  // Flags are registered from the next pointer so they line up with the PC update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      vazia_q <= 1'b1;
      cheia_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      vazia_q <= (ptr_d == '0);
      cheia_q <= (ptr_d == PW'(PROFUNDIDADE));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i)
      mem_q[ptr_q[PW-2:0]] <= dado_i;
  end

endmodule

// File: rtl/unidade_pc.sv
// Program counter and next-address unit: sequential/branch/jump/call/return
// selection, return-address stack, and sticky halt/error flags.
module unidade_pc
  import unidade_pc_pkg::*;
#(
  parameter int LARGURA_PC         = LARGURA_PC_PADRAO,
  parameter int PROFUNDIDADE_PILHA = PROFUNDIDADE_PADRAO
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Habilita,
  input  logic [2:0]            Operacao,
  input  logic                  Zero,
  input  logic [LARGURA_PC-1:0] Deslocamento,
  input  logic [LARGURA_PC-1:0] Destino,
  output logic [LARGURA_PC-1:0] PC,
  output logic                  PilhaVazia,
  output logic                  PilhaCheia,
  output logic                  Erro,
  output logic                  Parado
);

  operacao_t             op;
  logic                  executa;
  logic [LARGURA_PC-1:0] pc_q, pc_d, pc_mais1, pc_desvio, topo;
  logic                  erro_q, erro_d, parado_q, parado_d;
  logic                  push, pop;

  assign op        = operacao_t'(Operacao);
  assign executa   = Habilita && !parado_q;
  assign pc_mais1  = pc_q + LARGURA_PC'(1);
  // Same-width addition is the sign-extended offset add modulo 2^LARGURA_PC.
  assign pc_desvio = pc_q + Deslocamento;

  always_comb begin
    pc_d     = pc_q;
    erro_d   = erro_q;
    parado_d = parado_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (executa) begin
      unique case (op)
        OP_BEQ:  pc_d = Zero ? pc_desvio : pc_mais1;
        OP_BNE:  pc_d = Zero ? pc_mais1 : pc_desvio;
        OP_JMP:  pc_d = Destino;
        OP_CALL: begin
          if (!PilhaCheia) begin
            push = 1'b1;
            pc_d = Destino;
          end else begin
            erro_d   = 1'b1;
            parado_d = 1'b1;
          end
        end
        OP_RET: begin
          if (!PilhaVazia) begin
            pop  = 1'b1;
            pc_d = topo;
          end else begin
            erro_d   = 1'b1;
            parado_d = 1'b1;
          end
        end
        OP_HALT: parado_d = 1'b1;
        default: pc_d = pc_mais1;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q     <= '0;
      erro_q   <= 1'b0;
      parado_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      erro_q   <= erro_d;
      parado_q <= parado_d;
    end
  end

  pilha_retorno #(
    .LARGURA      (LARGURA_PC),
    .PROFUNDIDADE (PROFUNDIDADE_PILHA)
  ) u_pilha (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .dado_i  (pc_mais1),
    .topo_o  (topo),
    .vazia_o (PilhaVazia),
    .cheia_o (PilhaCheia)
  );

  assign PC     = pc_q;
  assign Erro   = erro_q;
  assign Parado = parado_q;

endmodule

// File: tb/tb_unidade_pc.sv
// Scoreboard bench for unidade_pc: each scenario queues the expected outputs
// per cycle and compares them against the sampled DUT outputs.
module tb_unidade_pc;

  logic       Clock = 1'b0;
  logic       Reset, Habilita, Zero;
  logic [2:0] Operacao;
  logic [7:0] Deslocamento, Destino, PC;
  logic       PilhaVazia, PilhaCheia, Erro, Parado;

  typedef struct packed {
    logic [7:0] pc;
    logic       vazia;
    logic       cheia;
    logic       erro;
    logic       parado;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [2:0] SEQ = 3'b000, BEQ = 3'b001, BNE = 3'b010, JMP = 3'b011,
                         CALL = 3'b100, RET = 3'b101, HALT = 3'b110, RES = 3'b111;

  unidade_pc #(.LARGURA_PC(8), .PROFUNDIDADE_PILHA(4)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Habilita     (Habilita),
    .Operacao     (Operacao),
    .Zero         (Zero),
    .Deslocamento (Deslocamento),
    .Destino      (Destino),
    .PC           (PC),
    .PilhaVazia   (PilhaVazia),
    .PilhaCheia   (PilhaCheia),
    .Erro         (Erro),
    .Parado       (Parado)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic [7:0] pc, input logic v, input logic c,
                              input logic e, input logic p);
    mk = '{pc: pc, vazia: v, cheia: c, erro: e, parado: p};
  endfunction

  task automatic step(input logic [2:0] op, input logic z, input logic [7:0] desl,
                      input logic [7:0] dest, input logic hab, input logic rst);
    Operacao = op; Zero = z; Deslocamento = desl; Destino = dest;
    Habilita = hab; Reset = rst;
    @(posedge Clock);
    #1;
    obs_q.push_back(mk(PC, PilhaVazia, PilhaCheia, Erro, Parado));
  endtask

  task automatic test_reset();
    obs_t e, o;
    exp_q.push_back(mk(8'h00, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 1);
    exp_q.push_back(mk(8'h00, 1, 0, 0, 0)); step(HALT, 0, 0, 8'h55, 1, 1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[%0d] got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_seq_stall();
    obs_t e, o;
    exp_q.push_back(mk(8'h00, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 1);
    exp_q.push_back(mk(8'h01, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h02, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h03, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h03, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(8'h03, 1, 0, 0, 0)); step(CALL, 0, 0, 8'h20, 0, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL seq_stall[%0d] got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_branch();
    obs_t e, o;
    exp_q.push_back(mk(8'h0A, 1, 0, 0, 0)); step(JMP, 0, 0, 8'h0A, 1, 0);
    exp_q.push_back(mk(8'h06, 1, 0, 0, 0)); step(BEQ, 1, 8'hFC, 0, 1, 0);
    exp_q.push_back(mk(8'h0A, 1, 0, 0, 0)); step(JMP, 0, 0, 8'h0A, 1, 0);
    exp_q.push_back(mk(8'h0B, 1, 0, 0, 0)); step(BEQ, 0, 8'hFC, 0, 1, 0);
    exp_q.push_back(mk(8'h0A, 1, 0, 0, 0)); step(JMP, 0, 0, 8'h0A, 1, 0);
    exp_q.push_back(mk(8'h06, 1, 0, 0, 0)); step(BNE, 0, 8'hFC, 0, 1, 0);
    exp_q.push_back(mk(8'h0A, 1, 0, 0, 0)); step(JMP, 0, 0, 8'h0A, 1, 0);
    exp_q.push_back(mk(8'h0B, 1, 0, 0, 0)); step(BNE, 1, 8'hFC, 0, 1, 0);
    exp_q.push_back(mk(8'h0B, 1, 0, 0, 0)); step(BEQ, 1, 8'h00, 0, 1, 0);
    exp_q.push_back(mk(8'h0C, 1, 0, 0, 0)); step(RES, 1, 8'h40, 8'h77, 1, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL branch[%0d] got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    exp_q.push_back(mk(8'hFE, 1, 0, 0, 0)); step(JMP, 0, 0, 8'hFE, 1, 0);
    exp_q.push_back(mk(8'h03, 1, 0, 0, 0)); step(BEQ, 1, 8'h05, 0, 1, 0);
    exp_q.push_back(mk(8'hFF, 1, 0, 0, 0)); step(JMP, 0, 0, 8'hFF, 1, 0);
    exp_q.push_back(mk(8'h00, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap[%0d] got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_call_ret();
    obs_t e, o;
    exp_q.push_back(mk(8'h00, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 1);
    exp_q.push_back(mk(8'h05, 1, 0, 0, 0)); step(JMP, 0, 0, 8'h05, 1, 0);
    exp_q.push_back(mk(8'h28, 0, 0, 0, 0)); step(CALL, 0, 0, 8'h28, 1, 0);
    exp_q.push_back(mk(8'h06, 1, 0, 0, 0)); step(RET, 0, 0, 0, 1, 0);
    // Nested calls return in LIFO order.
    exp_q.push_back(mk(8'h10, 0, 0, 0, 0)); step(CALL, 0, 0, 8'h10, 1, 0);
    exp_q.push_back(mk(8'h20, 0, 0, 0, 0)); step(CALL, 0, 0, 8'h20, 1, 0);
    exp_q.push_back(mk(8'h30, 0, 0, 0, 0)); step(CALL, 0, 0, 8'h30, 1, 0);
    exp_q.push_back(mk(8'h21, 0, 0, 0, 0)); step(RET, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h11, 0, 0, 0, 0)); step(RET, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h07, 1, 0, 0, 0)); step(RET, 0, 0, 0, 1, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL call_ret[%0d] got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_overflow();
    obs_t e, o;
    exp_q.push_back(mk(8'h00, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 1);
    exp_q.push_back(mk(8'h0A, 0, 0, 0, 0)); step(CALL, 0, 0, 8'h0A, 1, 0);
    exp_q.push_back(mk(8'h14, 0, 0, 0, 0)); step(CALL, 0, 0, 8'h14, 1, 0);
    exp_q.push_back(mk(8'h1E, 0, 0, 0, 0)); step(CALL, 0, 0, 8'h1E, 1, 0);
    exp_q.push_back(mk(8'h28, 0, 1, 0, 0)); step(CALL, 0, 0, 8'h28, 1, 0);
    exp_q.push_back(mk(8'h28, 0, 1, 1, 1)); step(CALL, 0, 0, 8'h32, 1, 0);
    exp_q.push_back(mk(8'h28, 0, 1, 1, 1)); step(SEQ, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h28, 0, 1, 1, 1)); step(RET, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h00, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 1);
    exp_q.push_back(mk(8'h01, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL overflow[%0d] got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_underflow_halt();
    obs_t e, o;
    exp_q.push_back(mk(8'h00, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 1);
    exp_q.push_back(mk(8'h01, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h01, 1, 0, 1, 1)); step(RET, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h01, 1, 0, 1, 1)); step(SEQ, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h00, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 1);
    exp_q.push_back(mk(8'h01, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h01, 1, 0, 0, 1)); step(HALT, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h01, 1, 0, 0, 1)); step(SEQ, 0, 0, 0, 1, 0);
    exp_q.push_back(mk(8'h01, 1, 0, 0, 1)); step(CALL, 0, 0, 8'h40, 1, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL underflow_halt[%0d] got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_call();
    obs_t e, o;
    exp_q.push_back(mk(8'h00, 1, 0, 0, 0)); step(SEQ, 0, 0, 0, 1, 1);
    exp_q.push_back(mk(8'h05, 1, 0, 0, 0)); step(JMP, 0, 0, 8'h05, 1, 0);
    exp_q.push_back(mk(8'h00, 1, 0, 0, 0)); step(CALL, 0, 0, 8'h40, 1, 1);
    // Empty stack after the reset-vs-call collision: a RET must underflow.
    exp_q.push_back(mk(8'h00, 1, 0, 1, 1)); step(RET, 0, 0, 0, 1, 0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_call[%0d] got %h want %h", i, o, e);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Habilita = 1'b0; Operacao = SEQ; Zero = 1'b0;
    Deslocamento = '0; Destino = '0;
    @(negedge Clock);
    test_reset();
    test_seq_stall();
    test_branch();
    test_wrap();
    test_call_ret();
    test_overflow();
    test_underflow_halt();
    test_reset_call();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
